// File: rtl/reloj24_bus_pkg.sv
// ============================================================================
//  Module   : reloj24_bus_pkg
//  Brief    : Shared address map and digit maxima for the 24h BCD clock.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package reloj24_bus_pkg;

   localparam int ADDR_W  = 3;
   localparam int DIGIT_W = 4;

   // Digit select addresses on the shared bus; 110 and 111 release the bus.
   localparam logic [ADDR_W-1:0] ADDR_US = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_DS = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_UM = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_DM = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_UH = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_DH = 3'd5;

   localparam logic [DIGIT_W-1:0] MAX_US      = 4'd9;
   localparam logic [DIGIT_W-1:0] MAX_DS      = 4'd5;
   localparam logic [DIGIT_W-1:0] MAX_UM      = 4'd9;
   localparam logic [DIGIT_W-1:0] MAX_DM      = 4'd5;
   localparam logic [DIGIT_W-1:0] MAX_UH      = 4'd9;
   localparam logic [DIGIT_W-1:0] MAX_UH_LAST = 4'd3;
   localparam logic [DIGIT_W-1:0] MAX_DH      = 4'd2;

   localparam logic [DIGIT_W-1:0] BUS_RELEASED = 4'bzzzz;

   typedef struct packed {
      logic [DIGIT_W-1:0] dh;
      logic [DIGIT_W-1:0] uh;
      logic [DIGIT_W-1:0] dm;
      logic [DIGIT_W-1:0] um;
      logic [DIGIT_W-1:0] ds;
      logic [DIGIT_W-1:0] us;
   } digits_t;

   function automatic logic addr_is_digit(input logic [ADDR_W-1:0] addr);
      return (addr <= ADDR_DH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/reloj24_bus_if.sv
// ============================================================================
//  Module   : reloj24_bus_if
//  Brief    : Multiplexed digit bus: address in, selected BCD digit out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface reloj24_bus_if;
   import reloj24_bus_pkg::*;

   logic [ADDR_W-1:0]  direccion;
   logic [DIGIT_W-1:0] BUS;

   modport master (output direccion, input BUS);
   modport slave  (input direccion, output BUS);

endinterface

`default_nettype wire

// File: rtl/reloj24_bus_bcd_digit_counter.sv
// ============================================================================
//  Module   : bcd_digit_counter
//  Brief    : One BCD digit 0..MAX with enable, forced wrap and carry out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_counter
   import reloj24_bus_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               wrap,
   output logic [DIGIT_W-1:0] q,
   output logic               carry
);

   logic [DIGIT_W-1:0] r_q;

   // Values above MAX cannot occur after reset, but still fall back to 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (en) begin
         if (wrap || (r_q >= MAX)) begin
            r_q <= '0;
         end else begin
            r_q <= r_q + 4'd1;
         end
      end
   end

   assign q     = r_q;
   assign carry = en && (r_q == MAX);

endmodule

`default_nettype wire

// File: rtl/reloj24_bus.sv
// ============================================================================
//  Module   : reloj24_bus
//  Brief    : 24h HH:MM:SS BCD clock with a 3-bit addressed tri-state digit bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reloj24_bus
   import reloj24_bus_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   reloj24_bus_if.slave  digit_bus
);

   logic w_tick;

   generate
      if (TICK_DIV <= 1) begin : g_tick_every_clk
         assign w_tick = 1'b1;
      end else begin : g_prescaler
         localparam int PRESC_W = $clog2(TICK_DIV);
         localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

         logic [PRESC_W-1:0] r_presc;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_presc <= '0;
            end else if (r_presc == PRESC_LAST) begin
               r_presc <= '0;
            end else begin
               r_presc <= r_presc + 1'b1;
            end
         end

         assign w_tick = (r_presc == PRESC_LAST);
      end
   endgenerate

   digits_t w_digits;

   logic w_us_carry, w_ds_carry, w_um_carry, w_dm_carry, w_uh_carry, w_dh_carry;
   logic w_uh_en, w_dh_en;
   logic w_hour_wrap;

   // 23 -> 00: Uh is forced back to 0 and Dh (already at its max) wraps too.
   assign w_hour_wrap = (w_digits.dh == MAX_DH) && (w_digits.uh == MAX_UH_LAST);
   assign w_uh_en     = w_dm_carry;
   assign w_dh_en     = w_uh_carry || (w_uh_en && w_hour_wrap);

   bcd_digit_counter #(.MAX(MAX_US)) u_us (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_tick),
      .wrap  (1'b0),
      .q     (w_digits.us),
      .carry (w_us_carry)
   );

   bcd_digit_counter #(.MAX(MAX_DS)) u_ds (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_us_carry),
      .wrap  (1'b0),
      .q     (w_digits.ds),
      .carry (w_ds_carry)
   );

   bcd_digit_counter #(.MAX(MAX_UM)) u_um (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_ds_carry),
      .wrap  (1'b0),
      .q     (w_digits.um),
      .carry (w_um_carry)
   );

   bcd_digit_counter #(.MAX(MAX_DM)) u_dm (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_um_carry),
      .wrap  (1'b0),
      .q     (w_digits.dm),
      .carry (w_dm_carry)
   );

   bcd_digit_counter #(.MAX(MAX_UH)) u_uh (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_uh_en),
      .wrap  (w_hour_wrap),
      .q     (w_digits.uh),
      .carry (w_uh_carry)
   );

   bcd_digit_counter #(.MAX(MAX_DH)) u_dh (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_dh_en),
      .wrap  (1'b0),
      .q     (w_digits.dh),
      .carry (w_dh_carry)
   );

   logic [DIGIT_W-1:0] w_sel_digit;
   logic               w_sel_valid;

   always_comb begin
      w_sel_digit = '0;
      w_sel_valid = addr_is_digit(digit_bus.direccion);
      case (digit_bus.direccion)
         ADDR_US: w_sel_digit = w_digits.us;
         ADDR_DS: w_sel_digit = w_digits.ds;
         ADDR_UM: w_sel_digit = w_digits.um;
         ADDR_DM: w_sel_digit = w_digits.dm;
         ADDR_UH: w_sel_digit = w_digits.uh;
         ADDR_DH: w_sel_digit = w_digits.dh;
         default: w_sel_digit = '0;
      endcase
   end

   assign digit_bus.BUS = w_sel_valid ? w_sel_digit : BUS_RELEASED;

   logic w_unused;
   assign w_unused = w_dh_carry;

endmodule

`default_nettype wire

// File: tb/tb_reloj24_bus.sv
// ============================================================================
//  Module   : tb_reloj24_bus
//  Brief    : Directed checks of the 24h BCD clock and its digit bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reloj24_bus;
   import reloj24_bus_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic rst4_n;
   int   total = 0;
   int   bad   = 0;
   int   secs  = 0;
   logic done4 = 1'b0;

   always #10 clk = ~clk;

   reloj24_bus_if bif ();
   reloj24_bus_if bif4 ();

   reloj24_bus #(.TICK_DIV(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .digit_bus (bif)
   );

   reloj24_bus #(.TICK_DIV(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst4_n),
      .digit_bus (bif4)
   );

   // A released bus may read back as 0 on a two-state simulator.
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      logic ok;
      total++;
      ok = (obs === exp) || ((exp === 4'bzzzz) && (obs === 4'b0000));
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      while (secs < target) begin
         step();
         secs++;
      end
   endtask

   task automatic expect_digits(input string tag,
                                input logic [3:0] dh, input logic [3:0] uh,
                                input logic [3:0] dm, input logic [3:0] um,
                                input logic [3:0] ds, input logic [3:0] us);
      logic [3:0] e [6];
      e = '{us, ds, um, dm, uh, dh};
      for (int i = 0; i < 6; i++) begin
         bif.direccion = 3'(i);
         #1;
         chk($sformatf("%s addr%0d", tag, i), bif.BUS, e[i]);
      end
   endtask

   task automatic expect_released(input string tag);
      bif.direccion = 3'b110;
      #1;
      chk($sformatf("%s addr6", tag), bif.BUS, 4'bzzzz);
      bif.direccion = 3'b111;
      #1;
      chk($sformatf("%s addr7", tag), bif.BUS, 4'bzzzz);
   endtask

   initial begin
      #(95000 * 20);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Prescaled instance: Us steps on every 4th edge while the address wanders.
   initial begin
      rst4_n         = 1'b0;
      bif4.direccion = ADDR_US;
      step();
      step();
      rst4_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step();
         bif4.direccion = 3'($urandom_range(7, 0));
         #2;
         bif4.direccion = ADDR_US;
         #1;
         chk($sformatf("div4 us edge%0d", n), bif4.BUS, 4'(n / 4));
      end
      bif4.direccion = ADDR_DS;
      #1;
      chk("div4 ds", bif4.BUS, 4'd0);
      done4 = 1'b1;
   end

   initial begin
      rst_n         = 1'b0;
      bif.direccion = ADDR_US;
      step();
      step();
      expect_digits("reset", 0, 0, 0, 0, 0, 0);
      expect_released("reset");
      rst_n = 1'b1;
      secs  = 0;

      for (int k = 1; k <= 10; k++) begin
         step();
         secs++;
         bif.direccion = ADDR_US;
         #1;
         chk($sformatf("us k%0d", k), bif.BUS, 4'(k % 10));
      end
      bif.direccion = ADDR_DS;
      #1;
      chk("ds k10", bif.BUS, 4'd1);

      run_to(60);
      expect_digits("t00:01:00", 0, 0, 0, 1, 0, 0);
      run_to(600);
      expect_digits("t00:10:00", 0, 0, 1, 0, 0, 0);
      run_to(1200);
      expect_digits("t00:20:00", 0, 0, 2, 0, 0, 0);
      run_to(3600);
      expect_digits("t01:00:00", 0, 1, 0, 0, 0, 0);
      run_to(5025);
      expect_digits("t01:23:45", 0, 1, 2, 3, 4, 5);

      rst_n = 1'b0;
      step();
      expect_digits("midreset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      secs = 1;
      expect_digits("after release", 0, 0, 0, 0, 0, 1);

      run_to(35999);
      expect_digits("t09:59:59", 0, 9, 5, 9, 5, 9);
      run_to(36000);
      expect_digits("t10:00:00", 1, 0, 0, 0, 0, 0);
      run_to(71999);
      expect_digits("t19:59:59", 1, 9, 5, 9, 5, 9);
      run_to(72000);
      expect_digits("t20:00:00", 2, 0, 0, 0, 0, 0);
      run_to(86399);
      expect_digits("t23:59:59", 2, 3, 5, 9, 5, 9);
      expect_released("t23:59:59");
      run_to(86400);
      expect_digits("day wrap", 0, 0, 0, 0, 0, 0);

      while (!done4) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
